// File: rtl/axi_demux_sel.sv
// axi_demux_sel: decodes the AXI-lite address into a demux target, holds it for one serialised transaction
module axi_demux_sel #(
  parameter logic [31:0] SEL1_BASE = 32'h8000_0000,
  parameter logic [31:0] SEL1_MASK = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr_i,
  input  logic [2:0]  s_axi_awprot_i,
  input  logic        s_axi_awvalid_i,
  output logic        s_axi_awready_o,
  input  logic [31:0] s_axi_wdata_i,
  input  logic [3:0]  s_axi_wstrb_i,
  input  logic        s_axi_wvalid_i,
  output logic        s_axi_wready_o,
  output logic [1:0]  s_axi_bresp_o,
  output logic        s_axi_bvalid_o,
  input  logic        s_axi_bready_i,
  input  logic [31:0] s_axi_araddr_i,
  input  logic [2:0]  s_axi_arprot_i,
  input  logic        s_axi_arvalid_i,
  output logic        s_axi_arready_o,
  output logic [31:0] s_axi_rdata_o,
  output logic [1:0]  s_axi_rresp_o,
  output logic        s_axi_rvalid_o,
  input  logic        s_axi_rready_i,
  output logic [31:0] m_axi_awaddr_o,
  output logic [2:0]  m_axi_awprot_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  input  logic [1:0]  m_axi_bresp_i,
  input  logic        m_axi_bvalid_i,
  output logic        m_axi_bready_o,
  output logic [31:0] m_axi_araddr_o,
  output logic [2:0]  m_axi_arprot_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  input  logic [31:0] m_axi_rdata_i,
  input  logic [1:0]  m_axi_rresp_i,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o,
  output logic        selector_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, last_wr_q, last_wr_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
  logic wr, rd, b_open, contend, grant_wr, grant_rd;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic hit_aw, hit_ar;
  assign m_axi_awaddr_o = s_axi_awaddr_i;
  assign m_axi_awprot_o = s_axi_awprot_i;
  assign m_axi_wdata_o  = s_axi_wdata_i;
  assign m_axi_wstrb_o  = s_axi_wstrb_i;
  assign m_axi_araddr_o = s_axi_araddr_i;
  assign m_axi_arprot_o = s_axi_arprot_i;
  assign s_axi_bresp_o  = m_axi_bresp_i;
  assign s_axi_rdata_o  = m_axi_rdata_i;
  assign s_axi_rresp_o  = m_axi_rresp_i;
  assign hit_aw = (s_axi_awaddr_i & SEL1_MASK) == SEL1_BASE;
  assign hit_ar = (s_axi_araddr_i & SEL1_MASK) == SEL1_BASE;
  assign wr     = state_q == WR;
  assign rd     = state_q == RD;
  assign b_open = wr && aw_done_q && w_done_q;
  assign m_axi_awvalid_o = wr && !aw_done_q && s_axi_awvalid_i;
  assign s_axi_awready_o = wr && !aw_done_q && m_axi_awready_i;
  assign m_axi_wvalid_o  = wr && !w_done_q && s_axi_wvalid_i;
  assign s_axi_wready_o  = wr && !w_done_q && m_axi_wready_i;
  assign s_axi_bvalid_o  = b_open && m_axi_bvalid_i;
  assign m_axi_bready_o  = b_open && s_axi_bready_i;
  assign m_axi_arvalid_o = rd && !ar_done_q && s_axi_arvalid_i;
  assign s_axi_arready_o = rd && !ar_done_q && m_axi_arready_i;
  assign s_axi_rvalid_o  = rd && m_axi_rvalid_i;
  assign m_axi_rready_o  = rd && s_axi_rready_i;
  assign aw_hs = m_axi_awvalid_o && m_axi_awready_i;
  assign w_hs  = m_axi_wvalid_o && m_axi_wready_i;
  assign b_hs  = s_axi_bvalid_o && s_axi_bready_i;
  assign ar_hs = m_axi_arvalid_o && m_axi_arready_i;
  assign r_hs  = s_axi_rvalid_o && s_axi_rready_i;
  assign contend  = s_axi_awvalid_i && s_axi_arvalid_i;
  assign grant_wr = s_axi_awvalid_i && !(contend && last_wr_q);
  assign grant_rd = s_axi_arvalid_i && !grant_wr;
  assign selector_o = sel_q;
  assign busy_o     = state_q != IDLE;
  // Grant in IDLE, track per-channel completion, return to IDLE on the final response
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_wr_d = last_wr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d = WR;
          sel_d   = hit_aw;
        end else if (grant_rd) begin
          state_d = RD;
          sel_d   = hit_ar;
        end
        if (contend) last_wr_d = grant_wr;
      end
      WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) w_done_d = 1'b1;
        if (b_hs) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          ar_done_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State, selector and flag registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_wr_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_wr_q <= last_wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end
endmodule

// File: tb/tb_axi_demux_sel.sv
// tb_axi_demux_sel: scoreboard bench for the AXI-lite demux selector stage
module tb_axi_demux_sel;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0] s_awprot, s_arprot, m_awprot, m_arprot;
  logic [3:0] s_wstrb, m_wstrb;
  logic [1:0] s_bresp, s_rresp, m_bresp, m_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic selector, busy;
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_aw[$];
  logic [32:0] exp_ar[$];
  logic [31:0] exp_w[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs;
  logic m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
  logic got_aw, got_w, hold_w;
  int b_stall, b_cnt, r_cnt, mw_cnt;
  logic [1:0] bresp_next;
  logic [31:0] rdata_next;

  axi_demux_sel dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr_i(s_awaddr), .s_axi_awprot_i(s_awprot), .s_axi_awvalid_i(s_awvalid), .s_axi_awready_o(s_awready),
    .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb), .s_axi_wvalid_i(s_wvalid), .s_axi_wready_o(s_wready),
    .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(s_bready),
    .s_axi_araddr_i(s_araddr), .s_axi_arprot_i(s_arprot), .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready),
    .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready),
    .m_axi_awaddr_o(m_awaddr), .m_axi_awprot_o(m_awprot), .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
    .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
    .m_axi_araddr_o(m_araddr), .m_axi_arprot_o(m_arprot), .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
    .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready),
    .selector_o(selector), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic clear_tb;
    exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_b.delete(); exp_r.delete();
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_wstrb = 4'hF;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    m_awready = 1; m_wready = 1; m_arready = 1; m_bvalid = 0; m_rvalid = 0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0;
    s_aw_hs = 0; s_w_hs = 0; s_ar_hs = 0; s_b_hs = 0; s_r_hs = 0;
    m_aw_hs = 0; m_w_hs = 0; m_b_hs = 0; m_ar_hs = 0; m_r_hs = 0;
    got_aw = 0; got_w = 0; hold_w = 0; b_stall = 0; bresp_next = '0; rdata_next = '0;
  endtask

  task automatic apply_reset;
    rst = 1;
    clear_tb();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    b_cnt = 0; r_cnt = 0;
  endtask

  // Sample at negedge: record handshakes and check outputs against the scoreboard
  task automatic sample;
    logic [32:0] e33;
    logic [31:0] e32;
    logic [1:0]  e2;
    logic [33:0] e34;
    @(negedge clk);
    s_aw_hs = s_awvalid && s_awready;
    s_w_hs  = s_wvalid && s_wready;
    s_ar_hs = s_arvalid && s_arready;
    s_b_hs  = s_bvalid && s_bready;
    s_r_hs  = s_rvalid && s_rready;
    m_aw_hs = m_awvalid && m_awready;
    m_w_hs  = m_wvalid && m_wready;
    m_b_hs  = m_bvalid && m_bready;
    m_ar_hs = m_arvalid && m_arready;
    m_r_hs  = m_rvalid && m_rready;
    if (m_aw_hs) begin
      vectors++; e33 = 'x;
      if (exp_aw.size() > 0) e33 = exp_aw.pop_front();
      if ({selector, m_awaddr} !== e33) begin miscompares++; $display("FAIL sb_aw got %h want %h", {selector, m_awaddr}, e33); end
    end
    if (m_w_hs) begin
      vectors++; mw_cnt++; e32 = 'x;
      if (exp_w.size() > 0) e32 = exp_w.pop_front();
      if (m_wdata !== e32) begin miscompares++; $display("FAIL sb_w got %h want %h", m_wdata, e32); end
    end
    if (m_ar_hs) begin
      vectors++; e33 = 'x;
      if (exp_ar.size() > 0) e33 = exp_ar.pop_front();
      if ({selector, m_araddr} !== e33) begin miscompares++; $display("FAIL sb_ar got %h want %h", {selector, m_araddr}, e33); end
    end
    if (s_b_hs) begin
      vectors++; b_cnt++; e2 = 'x;
      if (exp_b.size() > 0) e2 = exp_b.pop_front();
      if (s_bresp !== e2) begin miscompares++; $display("FAIL sb_b got %b want %b", s_bresp, e2); end
    end
    if (s_r_hs) begin
      vectors++; r_cnt++; e34 = 'x;
      if (exp_r.size() > 0) e34 = exp_r.pop_front();
      if ({s_rresp, s_rdata} !== e34) begin miscompares++; $display("FAIL sb_r got %h want %h", {s_rresp, s_rdata}, e34); end
    end
  endtask

  // Step past the rising edge: retire upstream valids and run the downstream responder
  task automatic advance;
    @(posedge clk);
    #1;
    if (s_aw_hs) s_awvalid = 0;
    if (s_w_hs && !hold_w) s_wvalid = 0;
    if (s_ar_hs) s_arvalid = 0;
    if (m_aw_hs) got_aw = 1;
    if (m_w_hs) got_w = 1;
    if (m_b_hs) begin
      m_bvalid = 0; got_aw = 0; got_w = 0;
    end else if (got_aw && got_w && !m_bvalid) begin
      if (b_stall > 0) b_stall--;
      else begin m_bvalid = 1; m_bresp = bresp_next; end
    end
    if (m_r_hs) m_rvalid = 0;
    if (m_ar_hs) begin m_rvalid = 1; m_rdata = rdata_next; m_rresp = 2'b00; end
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic esel,
                           input logic [1:0] resp, input int stall, input logic toggle_ar);
    int n;
    logic done;
    exp_aw.push_back({esel, a}); exp_w.push_back(d); exp_b.push_back(resp);
    bresp_next = resp; b_stall = stall;
    s_awaddr = a; s_wdata = d; s_awvalid = 1; s_wvalid = 1;
    sample();
    vectors++;
    if ({busy, s_awready, s_wready, m_awvalid, m_wvalid} !== 5'b0) begin
      miscompares++; $display("FAIL wr_bubble got %b want 00000", {busy, s_awready, s_wready, m_awvalid, m_wvalid});
    end
    advance();
    done = 0; n = 0;
    while (!done && n < 40) begin
      sample(); n++;
      vectors++;
      if ({busy, selector, s_arready, m_arvalid} !== {1'b1, esel, 2'b00}) begin
        miscompares++; $display("FAIL wr_hold got %b want %b", {busy, selector, s_arready, m_arvalid}, {1'b1, esel, 2'b00});
      end
      done = s_b_hs;
      advance();
      if (toggle_ar) s_arvalid = done ? 1'b0 : !s_arvalid;
    end
    if (!done) begin miscompares++; $display("FAIL wr_timeout got no b want b handshake"); end
    sample();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle busy got %b want 0", busy); end
    advance();
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [31:0] d, input logic esel);
    int n;
    logic done;
    exp_ar.push_back({esel, a}); exp_r.push_back({2'b00, d});
    rdata_next = d;
    s_araddr = a; s_arvalid = 1;
    sample();
    vectors++;
    if ({busy, s_arready, m_arvalid} !== 3'b0) begin
      miscompares++; $display("FAIL rd_bubble got %b want 000", {busy, s_arready, m_arvalid});
    end
    advance();
    done = 0; n = 0;
    while (!done && n < 40) begin
      sample(); n++;
      vectors++;
      if ({busy, selector, s_awready, m_awvalid} !== {1'b1, esel, 2'b00}) begin
        miscompares++; $display("FAIL rd_hold got %b want %b", {busy, selector, s_awready, m_awvalid}, {1'b1, esel, 2'b00});
      end
      done = s_r_hs;
      advance();
    end
    if (!done) begin miscompares++; $display("FAIL rd_timeout got no r want r handshake"); end
    sample();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_idle busy got %b want 0", busy); end
    advance();
  endtask

  task automatic test_reset;
    rst = 1;
    clear_tb();
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_bvalid = 1; m_rvalid = 1;
    s_awaddr = 32'hA5A5_0000; s_araddr = 32'h8000_5A5A; s_wdata = 32'h0F0F_F0F0; s_wstrb = 4'h6;
    s_awprot = 3'h5; s_arprot = 3'h2; m_rdata = 32'hFEED_FACE; m_rresp = 2'b11; m_bresp = 2'b10;
    sample();
    vectors++;
    if ({busy, selector, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
         s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 12'b0) begin
      miscompares++; $display("FAIL reset_gating got %b want 0", {busy, selector, m_awvalid, m_wvalid, m_arvalid,
                              m_bready, m_rready, s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
    vectors++;
    if ({m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot} !==
        {32'hA5A5_0000, 32'h8000_5A5A, 32'h0F0F_F0F0, 4'h6, 3'h5, 3'h2}) begin
      miscompares++; $display("FAIL passthru_fwd got %h", {m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot});
    end
    vectors++;
    if ({s_rdata, s_rresp, s_bresp} !== {32'hFEED_FACE, 2'b11, 2'b10}) begin
      miscompares++; $display("FAIL passthru_rsp got %h want %h", {s_rdata, s_rresp, s_bresp}, {32'hFEED_FACE, 2'b11, 2'b10});
    end
    advance();
    rst = 0;
    clear_tb();
    b_cnt = 0; r_cnt = 0; mw_cnt = 0;
  endtask

  task automatic test_write;
    write_txn(32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 2'b00, 0, 1'b0);
  endtask

  task automatic test_read;
    read_txn(32'h8000_0040, 32'h1234_5678, 1'b1);
  endtask

  task automatic test_w_before_aw;
    int n, b0, c0;
    m_awready = 0; hold_w = 1;
    s_wdata = 32'h5555_AAAA; s_wvalid = 1;
    exp_w.push_back(32'h5555_AAAA); exp_aw.push_back({1'b0, 32'h0000_4000}); exp_b.push_back(2'b01);
    bresp_next = 2'b01; b_stall = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      vectors++;
      if ({busy, s_wready, m_wvalid} !== 3'b0) begin
        miscompares++; $display("FAIL wfirst_gated got %b want 000", {busy, s_wready, m_wvalid});
      end
      advance();
    end
    c0 = mw_cnt; b0 = b_cnt;
    s_awaddr = 32'h0000_4000; s_awvalid = 1;
    sample();
    advance();
    sample();
    vectors++;
    if ({busy, s_wready, s_awready, m_wvalid} !== 4'b1101) begin
      miscompares++; $display("FAIL wfirst_w_only got %b want 1101", {busy, s_wready, s_awready, m_wvalid});
    end
    advance();
    m_awready = 1;
    sample();
    vectors++;
    if ({m_wvalid, s_wready, m_awvalid} !== 3'b001) begin
      miscompares++; $display("FAIL wfirst_w_gated got %b want 001", {m_wvalid, s_wready, m_awvalid});
    end
    advance();
    n = 0;
    while (b_cnt == b0 && n < 20) begin sample(); n++; advance(); end
    if (b_cnt == b0) begin miscompares++; $display("FAIL wfirst_timeout got no b want b handshake"); end
    hold_w = 0; s_wvalid = 0;
    sample();
    vectors++;
    if ({busy, 8'(mw_cnt - c0)} !== {1'b0, 8'd1}) begin
      miscompares++; $display("FAIL wfirst_once busy=%b w_handshakes=%0d want busy=0 w_handshakes=1", busy, mw_cnt - c0);
    end
    advance();
  endtask

  task automatic test_boundary;
    s_araddr = 32'h8000_0000;
    write_txn(32'h8FFF_FFFC, 32'h0BAD_F00D, 1'b1, 2'b10, 5, 1'b1);
    write_txn(32'h9000_0000, 32'h0000_0001, 1'b0, 2'b00, 0, 1'b0);
    read_txn(32'h7FFF_FFFC, 32'h2468_ACE0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int n;
    apply_reset();
    exp_aw.push_back({1'b0, 32'h0000_2000}); exp_w.push_back(32'h1111_2222); exp_b.push_back(2'b00);
    exp_ar.push_back({1'b1, 32'h8000_0100}); exp_r.push_back({2'b00, 32'hCAFE_0001});
    exp_aw.push_back({1'b0, 32'h0000_3000}); exp_w.push_back(32'h3333_4444); exp_b.push_back(2'b00);
    rdata_next = 32'hCAFE_0001;
    s_awaddr = 32'h0000_2000; s_wdata = 32'h1111_2222; s_araddr = 32'h8000_0100;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    sample();
    advance();
    sample();
    vectors++;
    if ({busy, m_awvalid, m_arvalid, s_arready} !== 4'b1100) begin
      miscompares++; $display("FAIL cont_first got %b want 1100", {busy, m_awvalid, m_arvalid, s_arready});
    end
    advance();
    n = 0;
    while (b_cnt < 1 && n < 20) begin
      sample(); n++;
      vectors++;
      if ({s_arready, m_arvalid} !== 2'b00) begin
        miscompares++; $display("FAIL cont_ar_gated got %b want 00", {s_arready, m_arvalid});
      end
      advance();
    end
    s_awaddr = 32'h0000_3000; s_wdata = 32'h3333_4444; s_awvalid = 1; s_wvalid = 1;
    sample();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_idle busy got %b want 0", busy); end
    advance();
    sample();
    vectors++;
    if ({busy, selector, m_arvalid, m_awvalid} !== 4'b1110) begin
      miscompares++; $display("FAIL cont_second got %b want 1110", {busy, selector, m_arvalid, m_awvalid});
    end
    advance();
    n = 0;
    while ((b_cnt < 2 || r_cnt < 1) && n < 60) begin sample(); n++; advance(); end
    if (b_cnt < 2 || r_cnt < 1) begin miscompares++; $display("FAIL cont_timeout got b=%0d r=%0d want b=2 r=1", b_cnt, r_cnt); end
    sample();
    vectors++;
    if ({busy, 8'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b.size() + exp_r.size())} !== 9'b0) begin
      miscompares++; $display("FAIL cont_drain busy=%b pending=%0d want 0 0", busy,
                              exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b.size() + exp_r.size());
    end
    advance();
  endtask

  task automatic test_reset_mid;
    m_wready = 0;
    exp_aw.push_back({1'b1, 32'h8000_0010});
    s_awaddr = 32'h8000_0010; s_wdata = 32'h7777_7777; s_awvalid = 1; s_wvalid = 1;
    sample();
    advance();
    sample();
    advance();
    sample();
    vectors++;
    if ({busy, selector, m_awvalid, m_wvalid} !== 4'b1101) begin
      miscompares++; $display("FAIL rst_pre got %b want 1101", {busy, selector, m_awvalid, m_wvalid});
    end
    #2 rst = 1;
    #1;
    vectors++;
    if ({busy, selector, m_wvalid, s_wready} !== 4'b0) begin
      miscompares++; $display("FAIL rst_async got %b want 0000", {busy, selector, m_wvalid, s_wready});
    end
    clear_tb();
    advance();
    rst = 0;
    read_txn(32'h0000_0040, 32'h1357_9BDF, 1'b0);
  endtask

  initial begin
    b_cnt = 0; r_cnt = 0; mw_cnt = 0;
    test_reset();
    test_write();
    test_read();
    test_w_before_aw();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
